// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants, error classes and codeword-map helpers for the
// SECDED (72,64) engine.
//
// Contents:
//   DATA_WIDTH / ECC_WIDTH / CW_WIDTH : bus widths (only 64/8/72 are supported)
//   err_class_e                       : read-side error classification
//   is_pow2()                         : true for a non-zero power of two
//   data_pos()                        : codeword position (3..71) of data bit idx
package ecc_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ECC_WIDTH  = 8;
    localparam int CW_WIDTH   = DATA_WIDTH + ECC_WIDTH;
    localparam int HAM_BITS   = 7;   // Hamming check bits; ecc[7] is overall parity
    localparam int MAX_POS    = 71;  // highest populated codeword position

    typedef enum logic [1:0] {
        ERR_NONE,       // syndrome zero
        ERR_SBE_DATA,   // single-bit error in a data bit, corrected
        ERR_SBE_CHECK,  // single-bit error in a check bit, data untouched
        ERR_DBE         // uncorrectable
    } err_class_e;

    function automatic logic is_pow2(input logic [6:0] v);
        return (v != '0) && ((v & (v - 7'd1)) == '0);
    endfunction

    // Data bits fill the non-power-of-two positions in ascending order:
    // d0=3, d1=5, d2=6, d3=7, d4=9, ... d63=71.
    function automatic logic [6:0] data_pos(input int idx);
        int         cnt;
        logic [6:0] pos;
        cnt = 0;
        pos = '0;
        for (int p = 3; p <= MAX_POS; p++) begin
            if (!is_pow2(7'(p))) begin
                if (cnt == idx) pos = 7'(p);
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_engine_if.sv
// ecc_engine_if: CPU-side and DFI-side data path of the ECC engine plus the
// telemetry outputs to the failure-prediction block.
//
// master : the environment (CPU write port, DRAM read return, consumers)
// slave  : the ECC engine
//
//   wdata_cpu/wdata_valid          CPU write data, one-cycle qualifier
//   dfi_wdata                      encoded word {ecc, data} to DRAM
//   dfi_rdata/dfi_rdata_valid      word from DRAM, one-cycle qualifier
//   rdata_cpu/rdata_valid          corrected read data, one-cycle pulse
//   ml_syndrome, ml_err_sbe, ml_err_dbe, ml_err_in_parity   telemetry
interface ecc_engine_if;
    import ecc_pkg::*;

    logic [DATA_WIDTH-1:0] wdata_cpu;
    logic                  wdata_valid;
    logic [CW_WIDTH-1:0]   dfi_wdata;
    logic [CW_WIDTH-1:0]   dfi_rdata;
    logic                  dfi_rdata_valid;
    logic [DATA_WIDTH-1:0] rdata_cpu;
    logic                  rdata_valid;
    logic [ECC_WIDTH-1:0]  ml_syndrome;
    logic                  ml_err_sbe;
    logic                  ml_err_dbe;
    logic                  ml_err_in_parity;

    modport master (
        output wdata_cpu, wdata_valid, dfi_rdata, dfi_rdata_valid,
        input  dfi_wdata, rdata_cpu, rdata_valid,
               ml_syndrome, ml_err_sbe, ml_err_dbe, ml_err_in_parity
    );

    modport slave (
        input  wdata_cpu, wdata_valid, dfi_rdata, dfi_rdata_valid,
        output dfi_wdata, rdata_cpu, rdata_valid,
               ml_syndrome, ml_err_sbe, ml_err_dbe, ml_err_in_parity
    );

endinterface

// File: rtl/ecc_secded_enc.sv
// ecc_secded_enc: combinational SECDED (72,64) check-bit generator.
//
// Ports:
//   data [63:0] : data word
//   ecc  [7:0]  : ecc[6:0] Hamming bits, ecc[7] overall parity of data+ecc[6:0]
module ecc_secded_enc
    import ecc_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data,
    output logic [ECC_WIDTH-1:0]  ecc
);

    logic [HAM_BITS-1:0] ham;
    logic [6:0]          pos;

    // ham[i] covers every data bit whose codeword position has bit i set.
    always_comb begin
        // NOTE: every combinational variable gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        ham = '0;
        pos = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            pos = data_pos(j);
            for (int i = 0; i < HAM_BITS; i++) begin
                if (pos[i]) ham[i] = ham[i] ^ data[j];
            end
        end
    end

    assign ecc = {(^data) ^ (^ham), ham};

endmodule

// File: rtl/ecc_engine.sv
// ecc_engine: SECDED (72,64) ECC between the CPU data path and the DFI.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset, clears every output
//   bus  : ecc_engine_if.slave -- write encode path (1-cycle latency, held
//          until the next wdata_valid), read check/correct path (registered
//          on dfi_rdata_valid, rdata_valid pulses one cycle later) and
//          syndrome / error-class telemetry. The two paths are independent
//          and accept a new beat every cycle.
module ecc_engine
    import ecc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ecc_engine_if.slave  bus
);

    logic [ECC_WIDTH-1:0]  wr_ecc;
    logic [ECC_WIDTH-1:0]  rd_ecc;
    logic [DATA_WIDTH-1:0] raw_data;
    logic [ECC_WIDTH-1:0]  rx_ecc;
    logic [ECC_WIDTH-1:0]  diff;
    logic [ECC_WIDTH-1:0]  syn;
    logic [DATA_WIDTH-1:0] flip_mask;
    logic [DATA_WIDTH-1:0] corr_data;
    err_class_e            err_class;

    ecc_secded_enc u_wr_enc (
        .data (bus.wdata_cpu),
        .ecc  (wr_ecc)
    );

    // Recompute check bits over the received data for the syndrome.
    ecc_secded_enc u_rd_enc (
        .data (bus.dfi_rdata[DATA_WIDTH-1:0]),
        .ecc  (rd_ecc)
    );

    assign raw_data = bus.dfi_rdata[DATA_WIDTH-1:0];
    assign rx_ecc   = bus.dfi_rdata[CW_WIDTH-1:DATA_WIDTH];
    assign diff     = rd_ecc ^ rx_ecc;

    // Parity of all 72 received bits equals the parity of diff: rd_ecc[7]
    // already folds in the data and recomputed ecc[6:0], so those cancel and
    // only the received bits remain.
    assign syn = {^diff, diff[HAM_BITS-1:0]};

    // One-hot select of the data bit sitting at the syndrome position.
    always_comb begin
        flip_mask = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            flip_mask[j] = (data_pos(j) == syn[HAM_BITS-1:0]);
        end
    end

    always_comb begin
        err_class = ERR_NONE;
        corr_data = raw_data;
        if (syn == '0) begin
            err_class = ERR_NONE;
        end else if (syn[7]) begin
            // Odd overall parity: a single flip, unless the position is off
            // the end of the codeword (three or more flips).
            if (syn[HAM_BITS-1:0] == '0 || is_pow2(syn[HAM_BITS-1:0])) begin
                err_class = ERR_SBE_CHECK;
            end else if (int'(syn[HAM_BITS-1:0]) <= MAX_POS) begin
                err_class = ERR_SBE_DATA;
                corr_data = raw_data ^ flip_mask;
            end else begin
                err_class = ERR_DBE;
            end
        end else begin
            err_class = ERR_DBE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dfi_wdata        <= '0;
            bus.rdata_cpu        <= '0;
            bus.rdata_valid      <= 1'b0;
            bus.ml_syndrome      <= '0;
            bus.ml_err_sbe       <= 1'b0;
            bus.ml_err_dbe       <= 1'b0;
            bus.ml_err_in_parity <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all registered state so every
            // flop samples pre-edge values regardless of statement order.
            bus.rdata_valid <= bus.dfi_rdata_valid;
            if (bus.wdata_valid) begin
                bus.dfi_wdata <= {wr_ecc, bus.wdata_cpu};
            end
            if (bus.dfi_rdata_valid) begin
                bus.rdata_cpu        <= corr_data;
                bus.ml_syndrome      <= syn;
                bus.ml_err_sbe       <= (err_class == ERR_SBE_DATA) || (err_class == ERR_SBE_CHECK);
                bus.ml_err_dbe       <= (err_class == ERR_DBE);
                bus.ml_err_in_parity <= (err_class == ERR_SBE_CHECK);
            end
        end
    end

endmodule

// File: tb/tb_ecc_engine.sv
// tb_ecc_engine: self-checking bench for ecc_engine. Expected values come from
// a position-level Hamming model (codeword laid out as positions 1..71,
// syndrome = XOR of the positions of all set bits) plus directed constants.
module tb_ecc_engine;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  syn;
        logic        sbe;
        logic        dbe;
        logic        par;
    } rd_res_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    int idx_to_pos [64];   // data index -> codeword position
    int pos_to_bus [72];   // codeword position -> bus bit (entry 0 unused)

    ecc_engine_if bus ();

    ecc_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic void build_tables();
        int k;
        k = 0;
        pos_to_bus[0] = 71;
        for (int p = 1; p <= 71; p++) begin
            if ($countones(p) == 1) begin
                pos_to_bus[p] = 64 + $clog2(p);
            end else begin
                pos_to_bus[p] = k;
                idx_to_pos[k] = p;
                k++;
            end
        end
    endfunction

    function automatic logic [71:0] ref_encode(input logic [63:0] d);
        logic [71:0] w;
        logic        e;
        w = '0;
        w[63:0] = d;
        for (int i = 0; i < 7; i++) begin
            e = 1'b0;
            for (int j = 0; j < 64; j++) begin
                if (((idx_to_pos[j] >> i) & 1) == 1) e = e ^ d[j];
            end
            w[64 + i] = e;
        end
        w[71] = ^w[70:0];
        return w;
    endfunction

    function automatic rd_res_t ref_decode(input logic [71:0] r);
        rd_res_t res;
        int      sp;
        logic    ov;
        sp = 0;
        for (int p = 1; p <= 71; p++) begin
            if (r[pos_to_bus[p]]) sp = sp ^ p;
        end
        ov = ^r;
        res = '0;
        res.data = r[63:0];
        res.syn  = {ov, 7'(sp)};
        if (ov) begin
            if (sp == 0 || $countones(sp) == 1) begin
                res.sbe = 1'b1;
                res.par = 1'b1;
            end else if (sp <= 71) begin
                res.data[pos_to_bus[sp]] = ~res.data[pos_to_bus[sp]];
                res.sbe = 1'b1;
            end else begin
                res.dbe = 1'b1;
            end
        end else if (sp != 0) begin
            res.dbe = 1'b1;
        end
        return res;
    endfunction

    function automatic rd_res_t mk_res(input logic [63:0] d, input logic [7:0] s,
                                       input logic sbe, input logic dbe, input logic par);
        rd_res_t res;
        res.data = d;
        res.syn  = s;
        res.sbe  = sbe;
        res.dbe  = dbe;
        res.par  = par;
        return res;
    endfunction

    // Called at a falling edge; drives one beat and returns at the next
    // falling edge, where the registered results are stable.
    task automatic step(input logic wv, input logic [63:0] wd, input logic rv, input logic [71:0] rd);
        bus.wdata_valid     = wv;
        bus.wdata_cpu       = wd;
        bus.dfi_rdata_valid = rv;
        bus.dfi_rdata       = rd;
        @(negedge clk);
        bus.wdata_valid     = 1'b0;
        bus.dfi_rdata_valid = 1'b0;
    endtask

    task automatic check_read(input string tag, input rd_res_t e);
        check({tag, ".valid"}, 72'(bus.rdata_valid), 72'd1);
        check({tag, ".data"}, 72'(bus.rdata_cpu), 72'(e.data));
        check({tag, ".syn"}, 72'(bus.ml_syndrome), 72'(e.syn));
        check({tag, ".flags"}, 72'({bus.ml_err_sbe, bus.ml_err_dbe, bus.ml_err_in_parity}),
              72'({e.sbe, e.dbe, e.par}));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".dfi_wdata"}, bus.dfi_wdata, 72'd0);
        check({tag, ".rdata_cpu"}, 72'(bus.rdata_cpu), 72'd0);
        check({tag, ".rdata_valid"}, 72'(bus.rdata_valid), 72'd0);
        check({tag, ".ml"}, 72'({bus.ml_syndrome, bus.ml_err_sbe, bus.ml_err_dbe, bus.ml_err_in_parity}), 72'd0);
    endtask

    initial begin
        logic [63:0] d0;
        logic [71:0] w0;
        logic [63:0] d;
        logic [63:0] d2;
        logic [71:0] r;
        int          kind;
        int          b1;
        int          b2;
        int          b3;

        n_checks = 0;
        n_pass   = 0;
        build_tables();

        rst                 = 1'b1;
        bus.wdata_cpu       = '0;
        bus.wdata_valid     = 1'b0;
        bus.dfi_rdata       = '0;
        bus.dfi_rdata_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed write/loopback cases.
        d0 = 64'hAAAA_BBBB_CCCC_DDDD;
        w0 = ref_encode(d0);
        step(1'b1, d0, 1'b0, '0);
        check("wr_enc", bus.dfi_wdata, w0);
        check("wr_no_rvalid", 72'(bus.rdata_valid), 72'd0);
        step(1'b0, 64'hFFFF_0000_FFFF_0000, 1'b0, '0);
        check("wr_hold", bus.dfi_wdata, w0);

        step(1'b0, '0, 1'b1, w0);
        check_read("clean", mk_res(d0, 8'h00, 1'b0, 1'b0, 1'b0));
        step(1'b0, '0, 1'b0, '0);
        check("clean.pulse_end", 72'(bus.rdata_valid), 72'd0);
        check("clean.hold", 72'(bus.rdata_cpu), 72'(d0));

        step(1'b0, '0, 1'b1, w0 ^ (72'd1 << 5));
        check_read("sbe_d5", mk_res(d0, 8'h8A, 1'b1, 1'b0, 1'b0));
        step(1'b0, '0, 1'b1, w0 ^ (72'd1 << 64));
        check_read("sbe_ecc0", mk_res(d0, 8'h81, 1'b1, 1'b0, 1'b1));
        step(1'b0, '0, 1'b1, w0 ^ (72'd1 << 71));
        check_read("sbe_ecc7", mk_res(d0, 8'h80, 1'b1, 1'b0, 1'b1));
        step(1'b0, '0, 1'b1, w0 ^ (72'd3 << 10));
        check_read("dbe_10_11", mk_res(d0 ^ (64'd3 << 10), 8'h1E, 1'b0, 1'b1, 1'b0));
        // Three flips at positions 64, 8, 3 -> syndrome position 75, off the codeword.
        step(1'b0, '0, 1'b1, w0 ^ (72'd1 << 70) ^ (72'd1 << 67) ^ 72'd1);
        check_read("beyond71", mk_res(d0 ^ 64'd1, 8'hCB, 1'b0, 1'b1, 1'b0));

        // Back-to-back reads with a simultaneous write.
        d = 64'h0123_4567_89AB_CDEF;
        step(1'b1, d, 1'b1, w0 ^ (72'd1 << 63));
        check_read("b2b_a", mk_res(d0, ref_decode(w0 ^ (72'd1 << 63)).syn, 1'b1, 1'b0, 1'b0));
        check("b2b_wr", bus.dfi_wdata, ref_encode(d));
        step(1'b0, '0, 1'b1, ref_encode(d));
        check_read("b2b_b", mk_res(d, 8'h00, 1'b0, 1'b0, 1'b0));

        // Reset asserted while a read beat is being presented.
        step(1'b0, '0, 1'b1, w0 ^ (72'd3 << 10));
        bus.dfi_rdata       = w0 ^ (72'd1 << 5);
        bus.dfi_rdata_valid = 1'b1;
        #2 rst = 1'b1;
        #1 check_all_zero("rst_async");
        @(negedge clk);
        check_all_zero("rst_held");
        bus.dfi_rdata_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_pulse", 72'(bus.rdata_valid), 72'd0);
        step(1'b0, '0, 1'b1, w0);
        check_read("post_rst", mk_res(d0, 8'h00, 1'b0, 1'b0, 1'b0));

        // Random traffic: 0..3 flipped bits on the read side, concurrent writes.
        for (int it = 0; it < 40; it++) begin
            d    = {$urandom, $urandom};
            d2   = {$urandom, $urandom};
            r    = ref_encode(d);
            kind = $urandom_range(0, 3);
            b1   = $urandom_range(0, 71);
            b2   = (b1 + $urandom_range(1, 35)) % 72;
            b3   = (b1 + $urandom_range(36, 71)) % 72;
            if (kind >= 1) r[b1] = ~r[b1];
            if (kind >= 2) r[b2] = ~r[b2];
            if (kind >= 3) r[b3] = ~r[b3];
            step(1'b1, d2, 1'b1, r);
            check_read($sformatf("rand%0d", it), ref_decode(r));
            check($sformatf("rand%0d.wr", it), bus.dfi_wdata, ref_encode(d2));
            if ($urandom_range(0, 3) == 0) step(1'b0, '0, 1'b0, '0);
        end

        // Every single-bit flip of one random word must be corrected.
        d = {$urandom, $urandom};
        w0 = ref_encode(d);
        for (int b = 0; b < 72; b++) begin
            step(1'b0, '0, 1'b1, w0 ^ (72'd1 << b));
            check($sformatf("sweep%0d.data", b), 72'(bus.rdata_cpu), 72'(d));
            check($sformatf("sweep%0d.sbe_dbe", b), 72'({bus.ml_err_sbe, bus.ml_err_dbe}), 72'b10);
            check($sformatf("sweep%0d.par", b), 72'(bus.ml_err_in_parity), 72'(b >= 64));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ecc_engine.md
Name: ecc_engine

Overview:
SECDED (72,64) Hamming ECC engine between the CPU-side data path and the DFI DRAM interface. On write it encodes 64-bit CPU data into a 72-bit DFI word (data plus 8 check bits). On read it checks and corrects the 72-bit DFI word and returns corrected data to the CPU. It also exports syndrome and error-class telemetry to the ML failure-prediction block.

Parameters:
DATA_WIDTH, 64, CPU data width; only 64 is supported.
ECC_WIDTH, 8, check-bit width (7 Hamming bits + 1 overall parity); only 8 is supported.

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
wdata_cpu  in  64  write data from CPU
wdata_valid  in  1  qualifies wdata_cpu for one cycle
dfi_wdata  out  72  encoded word to DRAM; [63:0]=data, [71:64]=ecc[7:0]
dfi_rdata  in  72  word read from DRAM, same layout
dfi_rdata_valid  in  1  qualifies dfi_rdata for one cycle
rdata_cpu  out  64  corrected read data
rdata_valid  out  1  one-cycle pulse: new read result
ml_syndrome  out  8  syndrome of the last read
ml_err_sbe  out  1  last read had a single-bit error (corrected or benign)
ml_err_dbe  out  1  last read had an uncorrectable error
ml_err_in_parity  out  1  the single-bit error was located in a check bit

Behaviour:
- Reset: all outputs are driven to 0 immediately, regardless of clk. A reset mid-operation discards any in-flight result.
- Codeword map: codeword positions 1..71. Check bits ecc[i], i=0..6, sit at positions 2^i. Data bits d0..d63 fill the remaining positions in ascending order: d0=3, d1=5, d2=6, d3=7, d4=9, … d63=71.
- Encode: ecc[i] (i<7) = XOR of all data bits whose position has bit i set. ecc[7] = XOR of d[63:0] and ecc[6:0], so the overall parity of the 72 bits is even.
- Write path: on the rising edge where wdata_valid=1, dfi_wdata <= {ecc, wdata_cpu}. Latency is 1 cycle. dfi_wdata holds until the next wdata_valid.
- Read path: on the rising edge where dfi_rdata_valid=1, the block registers all read outputs.
  - s[6:0] = recomputed ecc[6:0] XOR received ecc[6:0].
  - s[7] = XOR of all 72 received bits.
  - ml_syndrome = s.
- Read classification:
  - s==0: clean. rdata_cpu = received data; sbe=dbe=parity=0.
  - s[7]=1, s[6:0]==0 or a power of two: check-bit error. rdata_cpu = received data uncorrected; sbe=1, parity=1, dbe=0.
  - s[7]=1, s[6:0] a data position (3..71, not a power of two): the data bit at that position is flipped; sbe=1, parity=0, dbe=0.
  - s[7]=1, s[6:0] > 71: uncorrectable. dbe=1, sbe=0, parity=0; raw data is passed through.
  - s[7]=0, s[6:0]!=0: double-bit error. dbe=1, sbe=0, parity=0; raw data is passed through, no correction.
- Read timing: rdata_valid pulses high for exactly 1 cycle, on the cycle after the dfi_rdata_valid edge. rdata_cpu, ml_* and the flags hold their values until the next dfi_rdata_valid.
- Read and write paths are independent; simultaneous wdata_valid and dfi_rdata_valid are both serviced in the same cycle.
- There is no backpressure: a new valid may arrive every cycle, and results are produced at full throughput.

Decomposition:
- Package ecc_pkg holds DATA_WIDTH/ECC_WIDTH constants, the data-index-to-position function, and a function is_pow2.
- One sub-module, ecc_secded_enc: combinational, 64-bit data in, 8-bit ecc out. It is instantiated twice, once on the write path and once on the read path for recompute.

Test Plan:
- Clean loopback: write 64'hAAAA_BBBB_CCCC_DDDD, then feed dfi_wdata back to dfi_rdata -> rdata_cpu = written value, syndrome 8'h00, sbe=dbe=parity=0, rdata_valid one-cycle pulse.
- Data SBE: loopback with bit 5 flipped (d5, position 10) -> rdata_cpu corrected to AAAA_BBBB_CCCC_DDDD, syndrome 8'h8A, sbe=1, parity=0, dbe=0.
- Check-bit SBE: loopback with bus bit 64 (ecc[0]) flipped -> data unchanged, syndrome 8'h81, sbe=1, parity=1, dbe=0. Also flip bit 71 -> syndrome 8'h80, sbe=1, parity=1.
- DBE: loopback with bits 10 and 11 flipped (positions 15, 17) -> syndrome 8'h1E, dbe=1, sbe=0, parity=0.
- Reset mid-read: assert rst while dfi_rdata_valid is high -> all outputs 0 immediately, no rdata_valid pulse.
- Exhaustive single-bit sweep: random data, flip each of the 72 bits in turn -> data always corrected, and parity=1 exactly for bits 64..71.
